// File: rtl/johnson_mon_pkg.sv
// rtl/johnson_mon_pkg.sv - shared types and helpers for the Johnson divider monitor
package johnson_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } mon_state_t;

    function automatic int lock_cnt_width(input int lock_periods);
        return $clog2(lock_periods + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-stage sampler of the divided signal with rise/fall decode
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
        end
    end

    assign rise = s1 & ~s2;
    assign fall = ~s1 & s2;

endmodule

// File: rtl/johnson_divider_monitor.sv
// rtl/johnson_divider_monitor.sv - phase/period checker for a Johnson-divided clock; JOHNSON_MON_DUTY_CHECK_EN enforces 50% duty
module johnson_divider_monitor #(
    parameter int EXPECTED_FLOPS = 5,
    parameter int CNT_W          = 8,
    parameter int LOCK_PERIODS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    import johnson_mon_pkg::*;

    localparam int                LW         = lock_cnt_width(LOCK_PERIODS);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W:0]    EXP_PERIOD = (CNT_W + 1)'(2 * EXPECTED_FLOPS);
    localparam logic [LW-1:0]     LOCK_MAX   = LW'(LOCK_PERIODS);
`ifdef JOHNSON_MON_DUTY_CHECK_EN
    localparam logic [CNT_W-1:0]  EXP_PHASE  = CNT_W'(EXPECTED_FLOPS);
`endif

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    mon_state_t       state;
    logic [LW-1:0]    lock_cnt;
    logic [LW-1:0]    lock_next;
    logic [CNT_W:0]   period_calc;
    logic             pass;
    logic             timeout;
    logic             check_fire;
    logic             err_set;

    sync_edge_detect u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Phase counter restarts at 1 so it equals the number of samples at the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise || fall) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        period_calc = {1'b0, high_len} + {1'b0, cnt};
`ifdef JOHNSON_MON_DUTY_CHECK_EN
        pass        = (high_len == EXP_PHASE) && (cnt == EXP_PHASE);
`else
        pass        = (period_calc == EXP_PERIOD);
`endif
        timeout     = (state != IDLE) && (cnt == CNT_MAX) && !rise && !fall;
        check_fire  = (state == MEAS_LOW) && rise;
        err_set     = timeout || (check_fire && !pass);
        lock_next   = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            high_len     <= '0;
            low_len      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            lock_cnt     <= '0;
        end else begin
            period_valid <= 1'b0;

            // A new error outranks a simultaneous clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            if (timeout) begin
                state    <= IDLE;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            high_len <= cnt;
                            state    <= MEAS_LOW;
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            low_len      <= cnt;
                            period       <= period_calc;
                            period_valid <= 1'b1;
                            state        <= MEAS_HIGH;
                            if (pass) begin
                                lock_cnt <= lock_next;
                                locked   <= (lock_next == LOCK_MAX);
                            end else begin
                                lock_cnt <= '0;
                                locked   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_johnson_divider_monitor.sv
// tb/tb_johnson_divider_monitor.sv - directed table-driven bench for johnson_divider_monitor
module tb_johnson_divider_monitor;

    import johnson_mon_pkg::*;

    localparam int CNT_W = 8;
`ifdef JOHNSON_MON_DUTY_CHECK_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             err_clr;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W:0]   period;
    logic             period_valid;
    logic             locked;
    logic             err;

    johnson_divider_monitor #(
        .EXPECTED_FLOPS (5),
        .CNT_W          (CNT_W),
        .LOCK_PERIODS   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .err_clr      (err_clr),
        .high_len     (high_len),
        .low_len      (low_len),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int               pv_cnt     = 0;
    logic [CNT_W-1:0] cap_high   = '0;
    logic [CNT_W-1:0] cap_low    = '0;
    logic [CNT_W:0]   cap_period = '0;
    logic             cap_locked = 1'b0;
    logic             cap_err    = 1'b0;

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            cap_high   = high_len;
            cap_low    = low_len;
            cap_period = period;
            cap_locked = locked;
            cap_err    = err;
            pv_cnt++;
        end
    end

    typedef struct {
        int hi;
        int lo;
        bit clr;
        int exp_pvs;
        int exp_high;
        int exp_low;
        int exp_period;
        bit exp_locked;
        bit exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = v;
            step();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_high_len"}, 32'(high_len), 0);
        check({tag, "_low_len"}, 32'(low_len), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_pv"}, 32'(period_valid), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int base;

        // Each row's expectations describe the period completed by this row's first rise.
        vecs[0]  = '{5, 5, 1'b0, 0, 0, 0, 0,  1'b0, 1'b0};
        vecs[1]  = '{5, 5, 1'b0, 1, 5, 5, 10, 1'b0, 1'b0};
        vecs[2]  = '{5, 5, 1'b0, 1, 5, 5, 10, 1'b0, 1'b0};
        vecs[3]  = '{5, 5, 1'b0, 1, 5, 5, 10, 1'b0, 1'b0};
        vecs[4]  = '{6, 5, 1'b0, 1, 5, 5, 10, 1'b1, 1'b0};
        vecs[5]  = '{5, 5, 1'b0, 1, 6, 5, 11, 1'b0, 1'b1};
        vecs[6]  = '{5, 5, 1'b0, 1, 5, 5, 10, 1'b0, 1'b1};
        vecs[7]  = '{5, 5, 1'b0, 1, 5, 5, 10, 1'b0, 1'b1};
        vecs[8]  = '{5, 5, 1'b0, 1, 5, 5, 10, 1'b0, 1'b1};
        vecs[9]  = '{5, 5, 1'b0, 1, 5, 5, 10, 1'b1, 1'b1};
        vecs[10] = '{4, 6, 1'b1, 1, 5, 5, 10, 1'b1, 1'b0};
        vecs[11] = '{4, 6, 1'b0, 1, 4, 6, 10, !DUTY, DUTY};
        vecs[12] = '{4, 6, 1'b0, 1, 4, 6, 10, !DUTY, DUTY};
        vecs[13] = '{4, 6, 1'b0, 1, 4, 6, 10, !DUTY, DUTY};
        vecs[14] = '{5, 5, 1'b0, 1, 4, 6, 10, !DUTY, DUTY};

        rst     = 1'b1;
        sig_in  = 1'b0;
        err_clr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_outputs_zero("reset");
        check("reset_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        drive(1'b0, 4);

        for (int r = 0; r < 15; r++) begin
            base    = pv_cnt;
            sig_in  = 1'b1;
            err_clr = vecs[r].clr;
            step();
            err_clr = 1'b0;
            drive(1'b1, vecs[r].hi - 1);
            drive(1'b0, vecs[r].lo);
            check($sformatf("row%0d_pvs", r), 32'(pv_cnt - base), 32'(vecs[r].exp_pvs));
            check($sformatf("row%0d_high", r), 32'(cap_high), 32'(vecs[r].exp_high));
            check($sformatf("row%0d_low", r), 32'(cap_low), 32'(vecs[r].exp_low));
            check($sformatf("row%0d_period", r), 32'(cap_period), 32'(vecs[r].exp_period));
            check($sformatf("row%0d_locked", r), 32'(cap_locked), 32'(vecs[r].exp_locked));
            check($sformatf("row%0d_err", r), 32'(cap_err), 32'(vecs[r].exp_err));
        end

        // Timeout: hold high far past counter saturation.
        base    = pv_cnt;
        sig_in  = 1'b1;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive(1'b1, 199);
        check("to_pre_err", 32'(err), 0);
        check("to_pre_state", 32'(dut.state), 32'(MEAS_HIGH));
        check("to_pre_pvs", 32'(pv_cnt - base), 1);
        drive(1'b1, 100);
        check("to_err", 32'(err), 1);
        check("to_locked", 32'(locked), 0);
        check("to_state", 32'(dut.state), 32'(IDLE));
        check("to_pvs", 32'(pv_cnt - base), 1);
        drive(1'b0, 10);
        check("to_err_sticky", 32'(err), 1);

        // Re-lock from IDLE, then reset mid-low-phase.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err", 32'(err), 0);
        base = pv_cnt;
        for (int p = 0; p < 5; p++) begin
            drive(1'b1, 5);
            drive(1'b0, 5);
        end
        drive(1'b1, 5);
        drive(1'b0, 2);
        check("relock_pvs", 32'(pv_cnt - base), 5);
        check("relock_locked", 32'(locked), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_keeps_locked", 32'(locked), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_outputs_zero("midrst");
        base = pv_cnt;
        drive(1'b0, 3);
        drive(1'b1, 5);
        drive(1'b0, 5);
        check("midrst_first_rise_pvs", 32'(pv_cnt - base), 0);
        drive(1'b1, 5);
        drive(1'b0, 5);
        check("midrst_second_rise_pvs", 32'(pv_cnt - base), 1);
        check("midrst_period", 32'(cap_period), 10);
        check("midrst_locked", 32'(cap_locked), 0);

        // Mismatch detected in the same cycle as err_clr.
        drive(1'b1, 6);
        drive(1'b0, 5);
        check("pre_clash_err", 32'(err), 0);
        sig_in = 1'b1;
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive(1'b1, 3);
        check("clash_period", 32'(cap_period), 11);
        check("clash_err", 32'(err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("final_clr_err", 32'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/johnson_divider_monitor.md
# johnson_divider_monitor

Receive-side checker for a divided clock produced by the N-flop twisted ring (Johnson) counter. It samples the divided signal in the source clock domain and measures the high phase, the low phase and the full period in clk cycles. It compares these against the expected 2N division ratio and reports lock or a sticky error. It sits beside the divider, or at the far end of a routed divided-clock net, as a built-in self-check.

## Interface
- EXPECTED_FLOPS, 5, flop count N of the source counter; expected period is 2N clk cycles.
- CNT_W, 8, width of the phase-length counter; must be at least 2.
- LOCK_PERIODS, 4, number of consecutive good periods required to assert locked; must be at least 1.
- clk  input  1  sole clock; sig_in is synchronous to it.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  divided signal under test.
- err_clr  input  1  single-cycle pulse that clears err.
- high_len  output  CNT_W  length of the last completed high phase.
- low_len  output  CNT_W  length of the last completed low phase.
- period  output  CNT_W+1  high_len + low_len of the last completed period.
- period_valid  output  1  one-cycle pulse when period updates.
- locked  output  1  divider is running at the expected ratio.
- err  output  1  sticky: a mismatch or timeout has occurred since the last clear.

## Operation
- Input pipeline:
  - s1 <= sig_in.
  - s2 <= s1.
  - rise = s1 & ~s2.
  - fall = ~s1 & s2.
- Phase counter `cnt`:
  - Loads 1 on rise or fall.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - Length of a phase = number of clk edges at which sig_in was sampled at that level.
- FSM states: IDLE, MEAS_HIGH, MEAS_LOW.
  - IDLE: ignore partial phases and do not count toward timeout. On rise, go to MEAS_HIGH.
  - MEAS_HIGH: on fall, high_len <= cnt and go to MEAS_LOW.
  - MEAS_LOW: on rise:
    - low_len <= cnt.
    - period <= high_len + cnt, zero-extended to CNT_W+1 bits with no overflow.
    - period_valid <= 1.
    - Run the check, then go to MEAS_HIGH.
- Timeout, in MEAS_HIGH or MEAS_LOW: if cnt reaches 2^CNT_W-1 with no edge:
  - Set err.
  - Clear the lock count and locked.
  - Go to IDLE.
  - Do not pulse period_valid.
- Check: a period passes when it equals 2*EXPECTED_FLOPS; see Configuration.
  - Pass: lock count increments, saturating at LOCK_PERIODS. locked = 1 when the count reaches LOCK_PERIODS.
  - Fail: lock count = 0, locked = 0, err = 1.
- err_clr clears err. If a set event and err_clr occur in the same cycle, set wins.
- locked is unaffected by err_clr.
- Reset values, including when reset is asserted mid-operation:
  - State IDLE; s1, s2 and cnt = 0.
  - high_len, low_len and period = 0.
  - period_valid, locked and err = 0.
  - Lock count = 0.

## Timing
- All outputs are registered.
- Let edge k be the first clk edge that samples sig_in high after low. rise is decoded in the cycle after edge k. period_valid, period, low_len and locked update at edge k+1, so they are visible one cycle later than s1.
- The first period_valid after IDLE follows the second observed rising edge.
- With LOCK_PERIODS = L, locked asserts coincident with the L-th consecutive passing period_valid.
- Minimum phase length handled is 1 cycle: sig_in toggling every clk gives high_len = low_len = 1 and period = 2.

## Configuration
- Macro: JOHNSON_MON_DUTY_CHECK_EN.
- Defined: a period passes only if high_len == EXPECTED_FLOPS and low_len == EXPECTED_FLOPS, i.e. 50% duty cycle is enforced.
- Undefined: a period passes if period == 2*EXPECTED_FLOPS, with any high/low split.
- Output ports and timing are identical in both builds.

## Structure
- Package johnson_mon_pkg:
  - FSM state enum typedef (IDLE, MEAS_HIGH, MEAS_LOW).
  - Function returning the lock-count width, $clog2(LOCK_PERIODS+1).
- Sub-module sync_edge_detect: the s1/s2 pipeline with rise/fall outputs, synchronous reset.
- Counter, FSM, check logic and lock logic stay in the top module.

## Test plan
- Drive a 5-flop Johnson pattern (5 high, 5 low), defaults:
  - Every period_valid reports high_len=5, low_len=5, period=10.
  - locked rises on the 4th period_valid.
  - err stays 0.
- Once locked, stretch one high phase to 6 cycles:
  - That period reports period=11.
  - locked falls and err = 1.
  - locked re-asserts after 4 further good periods.
  - err stays 1 until err_clr.
- Apply a 4 high / 6 low pattern:
  - With JOHNSON_MON_DUTY_CHECK_EN defined: err=1, never locked.
  - Without the macro: period=10 and locked.
- Hold sig_in high for 300 cycles while in MEAS_HIGH, CNT_W=8:
  - At cnt=255: err=1, locked=0, state IDLE, no period_valid.
- Assert rst for one cycle mid-low-phase while locked:
  - All outputs are 0 the next cycle.
  - The first period_valid after reset follows two further rising edges.
- Assert err_clr in the same cycle as a mismatch detection: err remains 1.
